// File: rtl/r4_car_counter.sv
// rtl/r4_car_counter.sv - road-4 queue counter fed by synchronized, debounced loop sensors
// Arrival/departure loops are synchronized, debounced to one pulse per vehicle, then counted.

module r4_car_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_event
);

  typedef enum logic [1:0] {IDLE, DET_ON, OCCUPIED, DET_OFF} state_t;

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] stab_q, stab_d;
  logic       event_q, event_d;
  logic [3:0] stab_inc;

  assign stab_inc = stab_q + 4'd1;
  assign o_event  = event_q;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    event_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sync) begin
          state_d = DET_ON;
          stab_d  = 4'd1;
        end
      end
      DET_ON: begin
        if (!i_sync) begin
          state_d = IDLE;
          stab_d  = 4'd0;
        end else if (stab_inc == LIMIT) begin
          state_d = OCCUPIED;
          stab_d  = 4'd0;
          event_d = 1'b1;
        end else begin
          stab_d = stab_inc;
        end
      end
      OCCUPIED: begin
        if (!i_sync) begin
          state_d = DET_OFF;
          stab_d  = 4'd1;
        end
      end
      DET_OFF: begin
        // A brief dropout while the vehicle is still on the loop returns here without a new event.
        if (i_sync) begin
          state_d = OCCUPIED;
          stab_d  = 4'd0;
        end else if (stab_inc == LIMIT) begin
          state_d = IDLE;
          stab_d  = 4'd0;
        end else begin
          stab_d = stab_inc;
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      stab_q  <= 4'd0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      event_q <= event_d;
    end
  end

endmodule

module r4_car_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_CNT         = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_arrive_sensor,
  input  logic       i_depart_sensor,
  input  logic       i_r4_green,
  input  logic       i_r4_green_l,
  input  logic       i_clr_err,
  output logic [3:0] o_r4_car_cnt,
  output logic       o_car_waiting,
  output logic       o_overflow,
  output logic       o_underflow
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_CNT);

  logic       arr_meta_q, arr_sync_q;
  logic       dep_meta_q, dep_sync_q;
  logic       arr_event, dep_event, dep_valid;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      arr_meta_q <= 1'b0;
      arr_sync_q <= 1'b0;
      dep_meta_q <= 1'b0;
      dep_sync_q <= 1'b0;
    end else begin
      arr_meta_q <= i_arrive_sensor;
      arr_sync_q <= arr_meta_q;
      dep_meta_q <= i_depart_sensor;
      dep_sync_q <= dep_meta_q;
    end
  end

  r4_car_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arr_deb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sync (arr_sync_q),
    .o_event(arr_event)
  );

  r4_car_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dep_deb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sync (dep_sync_q),
    .o_event(dep_event)
  );

  // Departures only count while road 4 actually has a green to leave on.
  assign dep_valid = dep_event & (i_r4_green | i_r4_green_l);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~i_clr_err;
    unf_d = unf_q & ~i_clr_err;
    if (arr_event && !dep_valid) begin
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
      else                 ovf_d = 1'b1;
    end else if (dep_valid && !arr_event) begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else               unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_r4_car_cnt  = cnt_q;
  assign o_car_waiting = (cnt_q != 4'd0);
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

endmodule

// File: doc/r4_car_counter.md
R4_CAR_COUNTER -- requirements
Module: r4_car_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples (range 2..15) needed to accept a sensor level change.
REQ-002 Parameter MAX_CNT, default 15, is the saturation ceiling of the queue count (fits 4 bits).
REQ-003 i_clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_arrive_sensor  input  1  raw road-4 stop-line loop, asynchronous, high while a vehicle is over the loop.
REQ-006 i_depart_sensor  input  1  raw road-4 exit loop, asynchronous, high while a vehicle is over the loop.
REQ-007 i_r4_green  input  1  road-4 through-green from the signal controller, synchronous to i_clk.
REQ-008 i_r4_green_l  input  1  road-4 left-turn green from the signal controller, synchronous to i_clk.
REQ-009 i_clr_err  input  1  synchronous single-cycle clear of the sticky error flags.
REQ-010 o_r4_car_cnt  output  4  registered count of vehicles queued on road 4; feeds the controller's car-count input.
REQ-011 o_car_waiting  output  1  high when o_r4_car_cnt is nonzero, decoded from the count register only.
REQ-012 o_overflow  output  1  sticky; an arrival was dropped at MAX_CNT.
REQ-013 o_underflow  output  1  sticky; a valid departure occurred at count 0.

Function
REQ-014 Each raw sensor SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-015 Each synchronized sensor SHALL drive an independent debounce FSM.
  - States: IDLE, DET_ON, OCCUPIED, DET_OFF.
  - Each FSM has a 4-bit stability counter.
REQ-016 IDLE: sync=1 -> DET_ON with stability counter=1; otherwise stay in IDLE.
REQ-017 DET_ON: sync=0 -> IDLE with no event; sync=1 -> counter+1.
  - When the counter reaches DEBOUNCE_CYCLES: -> OCCUPIED and assert a one-cycle event pulse.
REQ-018 OCCUPIED: sync=0 -> DET_OFF with counter=1; otherwise hold.
REQ-019 DET_OFF: sync=1 -> OCCUPIED with no new event; sync=0 -> counter+1.
  - When the counter reaches DEBOUNCE_CYCLES: -> IDLE.
REQ-020 Exactly one event pulse SHALL be produced per accepted vehicle, however long the vehicle stays on the loop.
REQ-021 A departure event SHALL be valid only when (i_r4_green | i_r4_green_l) is 1 in the cycle the pulse is asserted; otherwise it is discarded silently.
REQ-022 Count update SHALL be registered, one edge after the event pulse:
  - arrival only, cnt<MAX_CNT: cnt+1
  - arrival only, cnt==MAX_CNT: hold, set o_overflow
  - valid departure only, cnt>0: cnt-1
  - valid departure only, cnt==0: hold at 0, set o_underflow
  - arrival and valid departure in the same cycle: hold, no flag set
  - no event: hold
REQ-023 The count SHALL never wrap: no 15->0 and no 0->15 transition.
REQ-024 Total latency: if a raw sensor is stably high from before edge k, o_r4_car_cnt SHALL change after edge k+2+DEBOUNCE_CYCLES (6 cycles at default).
REQ-025 o_overflow and o_underflow SHALL set on their condition and clear only on i_clr_err=1 or reset.
  - A set condition in the same cycle as i_clr_err=1 wins; the flag stays 1.
REQ-026 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL have no effect on the count.

Reset
REQ-027 While i_rst=1, independent of i_clk:
  - o_r4_car_cnt=0, o_car_waiting=0, o_overflow=0, o_underflow=0
  - both FSMs in IDLE, stability counters=0
  - all synchronizer flops=0
REQ-028 Reset asserted mid-debounce or mid-count SHALL abort any pending event; no count update occurs on the first edge after reset release.
REQ-029 After release, a sensor already high SHALL be treated as a new arrival and counted after the full REQ-024 latency.

Verification
REQ-030 Arrival pulse high 20 cycles, greens low -> o_r4_car_cnt 0->1 exactly 6 cycles after the rise; o_car_waiting=1; no second increment at the fall.
REQ-031 Arrival glitch high 3 cycles, then a 2-cycle dropout inside a 10-cycle high -> count unchanged by the glitch; exactly +1 for the 10-cycle high.
REQ-032 Count=3, departure 20 cycles with greens=0 -> count stays 3; repeat with i_r4_green_l=1 -> count 2.
REQ-033 Arrival and departure events aligned in the same cycle, i_r4_green=1, count=5 -> count stays 5, no flags.
REQ-034 16 arrivals from 0 -> count saturates at 15 and o_overflow=1; i_clr_err pulse -> o_overflow=0, count stays 15; valid departure at count 0 -> o_underflow=1.
REQ-035 i_rst pulsed during DET_ON with count=7 -> all outputs 0 immediately (asynchronous); sensor still high after release -> count=1 after 6 cycles.
